// File: rtl/tlc_pkg.sv
// Shared traffic-light definitions: phase codes, lamp encodings and default durations.
package tlc_pkg;

   // Phase codes as presented on the phase output.
   typedef enum logic [2:0] {
      NsGreen  = 3'd0,
      NsYellow = 3'd1,
      EwGreen  = 3'd2,
      EwYellow = 3'd3,
      PedWalk  = 3'd4,
      AllRed   = 3'd5
   } phase_e;

   // Requester most recently given right-of-way, used for rotation.
   typedef enum logic [1:0] {
      SrvNs  = 2'd0,
      SrvEw  = 2'd1,
      SrvPed = 2'd2
   } served_e;

   // One-hot lamp encodings.
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   // Default durations in cycles, shared with the fixed-cycle controller.
   localparam int unsigned DEF_GREEN_MIN    = 5;
   localparam int unsigned DEF_GREEN_MAX    = 20;
   localparam int unsigned DEF_YELLOW_TIME  = 3;
   localparam int unsigned DEF_ALL_RED_TIME = 2;
   localparam int unsigned DEF_PED_TIME     = 10;
   localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag, used for the timed phases.
module phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   // Load on phase entry, otherwise count down and stop at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven phase scheduler for a four-way intersection with pedestrian
// service and per-direction emergency preemption.
module intersection_phase_scheduler
   import tlc_pkg::*;
#(
   parameter int unsigned GREEN_MIN    = DEF_GREEN_MIN,
   parameter int unsigned GREEN_MAX    = DEF_GREEN_MAX,
   parameter int unsigned YELLOW_TIME  = DEF_YELLOW_TIME,
   parameter int unsigned ALL_RED_TIME = DEF_ALL_RED_TIME,
   parameter int unsigned PED_TIME     = DEF_PED_TIME,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ns_req,
   input  logic       ew_req,
   input  logic       ped_req,
   input  logic       emg_ns,
   input  logic       emg_ew,
   output logic [2:0] ns_leds,
   output logic [2:0] ew_leds,
   output logic       ped_allow,
   output logic [2:0] phase,
   output logic       emg_active
);

   phase_e           state_q, state_d;
   served_e          last_served_q, last_served_d;
   logic             ped_pend_q, ped_pend_d;
   logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
   logic [CNT_W-1:0] green_elapsed;
   logic             entering;
   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             timer_done;
   logic             ns_leave;
   logic             ew_leave;
   phase_e           next_sel;

   // Elapsed green cycles including the current one, saturating at GREEN_MAX.
   assign green_elapsed = (green_cnt_q >= CNT_W'(GREEN_MAX)) ? CNT_W'(GREEN_MAX)
                                                             : green_cnt_q + CNT_W'(1);

   // Normal (non-emergency) green exit: min-green with own demand gone, or max-green.
   assign ns_leave = (ew_req || ped_pend_q) &&
                     (((green_elapsed >= CNT_W'(GREEN_MIN)) && !ns_req) ||
                      (green_elapsed >= CNT_W'(GREEN_MAX)));
   assign ew_leave = (ns_req || ped_pend_q) &&
                     (((green_elapsed >= CNT_W'(GREEN_MIN)) && !ew_req) ||
                      (green_elapsed >= CNT_W'(GREEN_MAX)));

   // Phase chosen when all-red clearance ends: emergencies first, then rotation.
   always_comb begin
      next_sel = NsGreen;
      if (emg_ns) begin
         next_sel = NsGreen;
      end else if (emg_ew) begin
         next_sel = EwGreen;
      end else begin
         case (last_served_q)
            SrvNs: begin
               if (ew_req)          next_sel = EwGreen;
               else if (ped_pend_q) next_sel = PedWalk;
               else                 next_sel = NsGreen;
            end
            SrvEw: begin
               if (ped_pend_q)      next_sel = PedWalk;
               else if (ns_req)     next_sel = NsGreen;
               else if (ew_req)     next_sel = EwGreen;
               else                 next_sel = NsGreen;
            end
            default: begin
               if (ns_req)          next_sel = NsGreen;
               else if (ew_req)     next_sel = EwGreen;
               else                 next_sel = NsGreen;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= NsGreen;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; emg_ns wins over emg_ew when both are asserted.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         NsGreen: begin
            if (emg_ns)                  state_d = NsGreen;
            else if (emg_ew || ns_leave) state_d = NsYellow;
         end
         EwGreen: begin
            if (emg_ns)                  state_d = EwYellow;
            else if (emg_ew)             state_d = EwGreen;
            else if (ew_leave)           state_d = EwYellow;
         end
         NsYellow, EwYellow: begin
            if (timer_done)              state_d = AllRed;
         end
         PedWalk: begin
            if (emg_ns || emg_ew || timer_done) state_d = AllRed;
         end
         AllRed: begin
            if (timer_done)              state_d = next_sel;
         end
         default:                        state_d = NsGreen;
      endcase
   end

   // Output decode from the registered state.
   always_comb begin
      ns_leds    = RED;
      ew_leds    = RED;
      ped_allow  = 1'b0;
      phase      = state_q;
      emg_active = ((state_q == NsGreen) && emg_ns) || ((state_q == EwGreen) && emg_ew);
      unique case (state_q)
         NsGreen:  ns_leds   = GREEN;
         NsYellow: ns_leds   = YELLOW;
         EwGreen:  ew_leds   = GREEN;
         EwYellow: ew_leds   = YELLOW;
         PedWalk:  ped_allow = 1'b1;
         AllRed:   ns_leds   = RED;
         default:  ns_leds   = RED;
      endcase
   end

   assign entering = (state_d != state_q);

   // Timer load value for the phase being entered; greens do not use the timer.
   always_comb begin
      timer_load = entering;
      case (state_d)
         NsYellow, EwYellow: timer_val = CNT_W'(YELLOW_TIME - 1);
         AllRed:             timer_val = CNT_W'(ALL_RED_TIME - 1);
         PedWalk:            timer_val = CNT_W'(PED_TIME - 1);
         default:            timer_val = '0;
      endcase
   end

   // Latch next-state: clearing the ped latch on walk entry beats a new press.
   always_comb begin
      ped_pend_d    = ped_pend_q;
      last_served_d = last_served_q;
      green_cnt_d   = green_cnt_q;
      if (entering && (state_d == PedWalk)) begin
         ped_pend_d = 1'b0;
      end else if (ped_req && (state_q != PedWalk)) begin
         ped_pend_d = 1'b1;
      end
      if (entering) begin
         case (state_d)
            NsGreen: last_served_d = SrvNs;
            EwGreen: last_served_d = SrvEw;
            PedWalk: last_served_d = SrvPed;
            default: last_served_d = last_served_q;
         endcase
      end
      if (entering) begin
         green_cnt_d = '0;
      end else if ((state_q == NsGreen) || (state_q == EwGreen)) begin
         green_cnt_d = green_elapsed;
      end
   end

   // Pedestrian latch, rotation pointer and elapsed-green counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         ped_pend_q    <= 1'b0;
         last_served_q <= SrvNs;
         green_cnt_q   <= '0;
      end else begin
         ped_pend_q    <= ped_pend_d;
         last_served_q <= last_served_d;
         green_cnt_q   <= green_cnt_d;
      end
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_phase_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: expected phase per cycle is queued up front and popped as cycles elapse.
module tb_intersection_phase_scheduler;

   localparam int PH_NSG = 0;
   localparam int PH_NSY = 1;
   localparam int PH_EWG = 2;
   localparam int PH_EWY = 3;
   localparam int PH_PED = 4;
   localparam int PH_AR  = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ns_req = 1'b0;
   logic       ew_req = 1'b0;
   logic       ped_req = 1'b0;
   logic       emg_ns = 1'b0;
   logic       emg_ew = 1'b0;
   logic [2:0] ns_leds;
   logic [2:0] ew_leds;
   logic       ped_allow;
   logic [2:0] phase;
   logic       emg_active;

   typedef struct {
      int cyc;
      int ph;
      bit emg;
   } exp_t;

   exp_t  sb[$];
   int    cyc;
   int    n_cmp = 0;
   int    n_err = 0;
   string tname;

   intersection_phase_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .ns_req     (ns_req),
      .ew_req     (ew_req),
      .ped_req    (ped_req),
      .emg_ns     (emg_ns),
      .emg_ew     (emg_ew),
      .ns_leds    (ns_leds),
      .ew_leds    (ew_leds),
      .ped_allow  (ped_allow),
      .phase      (phase),
      .emg_active (emg_active)
   );

   always #5 clk = ~clk;

   // Expected {ns_leds, ew_leds, ped_allow} for a phase code.
   function automatic logic [6:0] lamps_of(input int ph);
      case (ph)
         PH_NSG:  return {3'b001, 3'b100, 1'b0};
         PH_NSY:  return {3'b010, 3'b100, 1'b0};
         PH_EWG:  return {3'b100, 3'b001, 1'b0};
         PH_EWY:  return {3'b100, 3'b010, 1'b0};
         PH_PED:  return {3'b100, 3'b100, 1'b1};
         default: return {3'b100, 3'b100, 1'b0};
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic exp_span(input int a, input int b, input int ph, input bit emg);
      for (int c = a; c <= b; c++) begin
         exp_t e;
         e.cyc = c;
         e.ph  = ph;
         e.emg = emg;
         sb.push_back(e);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check_val($sformatf("%s c%0d phase", tname, cyc), 32'(phase), 32'(e.ph));
            check_val($sformatf("%s c%0d outs", tname, cyc),
                      32'({ns_leds, ew_leds, ped_allow, emg_active}),
                      32'({lamps_of(e.ph), e.emg}));
         end
      end
   endtask

   task automatic do_reset(input string name);
      tname   = name;
      ns_req  = 1'b0;
      ew_req  = 1'b0;
      ped_req = 1'b0;
      emg_ns  = 1'b0;
      emg_ew  = 1'b0;
      reset   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      sb.delete();
      check_val($sformatf("%s reset phase", name), 32'(phase), 32'(PH_NSG));
      check_val($sformatf("%s reset outs", name),
                32'({ns_leds, ew_leds, ped_allow, emg_active}), 32'({lamps_of(PH_NSG), 1'b0}));
   endtask

   task automatic drain_check();
      check_val($sformatf("%s sb_left", tname), 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Idle: NS rests green.
      do_reset("idle");
      exp_span(1, 100, PH_NSG, 1'b0);
      step(100);
      drain_check();

      // EW demand only: NS leaves after min green.
      do_reset("ew_only");
      ew_req = 1'b1;
      exp_span(1, 4, PH_NSG, 1'b0);
      exp_span(5, 7, PH_NSY, 1'b0);
      exp_span(8, 9, PH_AR, 1'b0);
      exp_span(10, 40, PH_EWG, 1'b0);
      step(40);
      drain_check();

      // Both directions: max-green alternation.
      do_reset("both");
      ns_req = 1'b1;
      ew_req = 1'b1;
      exp_span(1, 19, PH_NSG, 1'b0);
      exp_span(20, 22, PH_NSY, 1'b0);
      exp_span(23, 24, PH_AR, 1'b0);
      exp_span(25, 44, PH_EWG, 1'b0);
      exp_span(45, 47, PH_EWY, 1'b0);
      exp_span(48, 49, PH_AR, 1'b0);
      exp_span(50, 69, PH_NSG, 1'b0);
      exp_span(70, 72, PH_NSY, 1'b0);
      step(72);
      drain_check();

      // Pedestrian pulse with EW demand; EW released during walk so NS follows.
      do_reset("ped");
      ew_req = 1'b1;
      exp_span(1, 4, PH_NSG, 1'b0);
      exp_span(5, 7, PH_NSY, 1'b0);
      exp_span(8, 9, PH_AR, 1'b0);
      exp_span(10, 29, PH_EWG, 1'b0);
      exp_span(30, 32, PH_EWY, 1'b0);
      exp_span(33, 34, PH_AR, 1'b0);
      exp_span(35, 44, PH_PED, 1'b0);
      exp_span(45, 46, PH_AR, 1'b0);
      exp_span(47, 51, PH_NSG, 1'b0);
      exp_span(52, 54, PH_NSY, 1'b0);
      exp_span(55, 56, PH_AR, 1'b0);
      exp_span(57, 80, PH_EWG, 1'b0);
      step(1);
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      step(34);
      ew_req = 1'b0;
      step(11);
      ew_req = 1'b1;
      step(33);
      drain_check();

      // EW emergency preempts NS green and holds against NS demand.
      do_reset("emg_ew");
      ns_req = 1'b1;
      exp_span(1, 1, PH_NSG, 1'b0);
      exp_span(2, 4, PH_NSY, 1'b0);
      exp_span(5, 6, PH_AR, 1'b0);
      exp_span(7, 56, PH_EWG, 1'b1);
      exp_span(57, 59, PH_EWY, 1'b0);
      step(1);
      emg_ew = 1'b1;
      step(55);
      emg_ew = 1'b0;
      step(3);
      drain_check();

      // Reset mid-walk returns to NS green with no further walk.
      do_reset("rst_walk");
      exp_span(1, 4, PH_NSG, 1'b0);
      exp_span(5, 7, PH_NSY, 1'b0);
      exp_span(8, 9, PH_AR, 1'b0);
      exp_span(10, 13, PH_PED, 1'b0);
      exp_span(14, 60, PH_NSG, 1'b0);
      step(1);
      ped_req = 1'b1;
      step(1);
      ped_req = 1'b0;
      step(11);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(46);
      drain_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
